counter_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit interval counter among several requesters. Each requester asks for a timed interval of programmable length. The block grants the counter to one requester at a time, runs the count, and signals completion to the winner. It sits between the control agents and the shared up-counter, which it owns as a sub-module and sequences through clear, enable and terminal-count detection.

---
 rtl/counter_sched_pkg.sv | 21 ++
 rtl/counter_sched_if.sv | 27 ++
 rtl/counter_core.sv | 23 ++
 rtl/counter_sched.sv | 101 ++++++++++
 tb/tb_counter_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// counter_sched shared types, defaults and helpers.
// Imported by the interface, the scheduler and its bench.
package counter_sched_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 4;
  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAX_NREQ-1:0] onehot(
    input int unsigned idx
  );
    onehot = MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side bundle of the shared-counter scheduler.
// master = requester agents, slave = scheduler.
interface counter_sched_if
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      q;

  modport master (
    output req, len,
    input  gnt, done, busy, q
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, q
  );

endinterface

// File: rtl/counter_core.sv
// Shared CW-bit up-counter with synchronous clear and enable.
// Clear has priority over enable.
module counter_core #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CW'(1);
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one interval counter.
// ptr holds the current/last winner; search starts at ptr+1.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic           clk,
  input  logic           reset,
  counter_sched_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic [CW-1:0] len_l;
  logic [CW-1:0] q;
  logic          hit;
  logic          hold;
  logic          clr;
  logic          en;

  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign hit  = (q == len_l);
  assign hold = bus.req[ptr];
  assign clr  = (state == IDLE) && found;
  assign en   = (state == RUN) && hold && !hit;

  counter_core #(
    .CW(CW)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .q    (q)
  );

  assign bus.q = q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      len_l    <= '0;
      bus.gnt  <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= RUN;
            ptr      <= win;
            len_l    <= bus.len[win*CW +: CW];
            bus.gnt  <= NREQ'(onehot(win));
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          // abort outranks completion on the same edge
          if (!hold) begin
            state    <= IDLE;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
          end else if (hit) begin
            state    <= DONE;
            bus.done <= bus.gnt;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: interval-level reference model
// compared every cycle, plus directed literal checks.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic reset;

  counter_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

  counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: who owns the counter, its count, its limit,
  // and whether the completion cycle is being shown.
  int m_own;
  bit m_dn;
  int m_q;
  int m_lim;
  int m_last;

  task automatic m_reset();
    m_own  = -1;
    m_dn   = 1'b0;
    m_q    = 0;
    m_lim  = 0;
    m_last = NREQ - 1;
  endtask

  task automatic m_step();
    if (m_own < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (bus.req[j]) begin
          m_own  = j;
          m_last = j;
          m_q    = 0;
          m_lim  = int'(bus.len[j*CW +: CW]);
          break;
        end
      end
    end else if (m_dn) begin
      m_own = -1;
      m_dn  = 1'b0;
    end else if (!bus.req[m_own]) begin
      m_own = -1;
    end else if (m_q == m_lim) begin
      m_dn = 1'b1;
    end else begin
      m_q = m_q + 1;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    int eg;
    eg = (m_own < 0) ? 0 : (1 << m_own);
    chk("m_gnt", 32'(bus.gnt), eg);
    chk("m_done", 32'(bus.done), m_dn ? eg : 0);
    chk("m_busy", 32'(bus.busy), 32'(m_own >= 0));
    chk("m_q", 32'(bus.q), m_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gi[$];
    int gc[$];
    int rr_exp[5];
    logic [3:0] pg;
    bit saw;
    int n;

    rr_exp = '{0, 1, 2, 3, 0};
    reset   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // single request, len 3
    bus.len[3:0] = 4'd3;
    bus.req      = 4'b0001;
    tick();
    chk("t1_gnt", 32'(bus.gnt), 1);
    chk("t1_q0", 32'(bus.q), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_q", 32'(bus.q), i);
      chk("t1_nodone", 32'(bus.done), 0);
    end
    tick();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_qhold", 32'(bus.q), 3);
    tick();
    chk("t1_gnt_off", 32'(bus.gnt), 0);
    chk("t1_busy_off", 32'(bus.busy), 0);
    bus.req = '0;
    tick();

    // round robin from a fresh reset
    reset = 1'b0;
    #2 reset = 1'b1;
    bus.len = '0;
    bus.req = 4'b1111;
    pg = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.gnt != 0 && pg == 0) begin
        gi.push_back($clog2(bus.gnt));
        gc.push_back(c);
      end
      pg = bus.gnt;
    end
    chk("rr_count", gi.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gi.size()) chk("rr_order", gi[i], rr_exp[i]);
      if (i > 0 && i < gc.size())
        chk("rr_space", gc[i] - gc[i-1], 3);
    end
    bus.req = '0;
    repeat (4) tick();

    // abort at q == 4
    bus.len[11:8] = 4'd10;
    bus.req       = 4'b0100;
    saw = 1'b0;
    for (int i = 0; i < 10 && bus.gnt != 4'b0100; i++) tick();
    chk("ab_grant", 32'(bus.gnt), 4'b0100);
    for (int i = 0; i < 20 && bus.q != 4; i++) begin
      tick();
      saw |= |bus.done;
    end
    chk("ab_q4", 32'(bus.q), 4);
    bus.req = '0;
    tick();
    saw |= |bus.done;
    chk("ab_gnt_off", 32'(bus.gnt), 0);
    chk("ab_qhold", 32'(bus.q), 4);
    repeat (2) begin
      tick();
      saw |= |bus.done;
    end
    chk("ab_nodone", 32'(saw), 0);
    bus.req = 4'b0100;
    tick();
    chk("ab_regrant", 32'(bus.gnt), 4'b0100);
    chk("ab_q_restart", 32'(bus.q), 0);
    bus.req = '0;
    repeat (3) tick();

    // len 15, changed to 2 after grant
    bus.len[7:4] = 4'd15;
    bus.req      = 4'b0010;
    tick();
    chk("l15_gnt", 32'(bus.gnt), 4'b0010);
    bus.len[7:4] = 4'd2;
    n = 0;
    while (n < 30 && bus.done == 0) begin
      tick();
      n++;
    end
    chk("l15_latency", n, 16);
    chk("l15_qmax", 32'(bus.q), 15);
    chk("l15_done", 32'(bus.done), 4'b0010);
    bus.req = '0;
    repeat (3) tick();

    // asynchronous reset while q == 5
    bus.len[15:12] = 4'd15;
    bus.req        = 4'b1000;
    for (int i = 0; i < 20 && bus.q != 5; i++) tick();
    chk("rs_q5", 32'(bus.q), 5);
    #2 reset = 1'b0;
    #1;
    chk("rs_gnt", 32'(bus.gnt), 0);
    chk("rs_done", 32'(bus.done), 0);
    chk("rs_busy", 32'(bus.busy), 0);
    chk("rs_q", 32'(bus.q), 0);
    bus.req = 4'b1001;
    #1 reset = 1'b1;
    tick();
    chk("rs_prio", 32'(bus.gnt), 4'b0001);
    bus.req = '0;
    repeat (3) tick();

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
      if ($urandom_range(0, 3) == 0) bus.len = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
      tick();
    end

    bus.req = '0;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
